instruction_fetch_unit: RTL and testbench
=========================================

INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

Interface
REQ-001 SHALL have parameter WORD_SIZE, default 32, instruction/address width.
REQ-002 SHALL have parameter RESET_PC, default 32'h0000_0000, first fetch address.
REQ-003 SHALL have parameter DEPTH, default 2, fetch-buffer entries and maximum requests in flight (power of 2, >=2).
REQ-004 SHALL have port clk  in  1  sole clock, all state updates on rising edge.
REQ-005 SHALL have port reset_n  in  1  synchronous, active-low reset.
REQ-006 SHALL have port ImemReqValid  out  1  fetch request valid.
REQ-007 SHALL have port ImemReqReady  in  1  memory accepts request.
REQ-008 SHALL have port ImemReqAddr  out  WORD_SIZE  fetch address, word aligned.
REQ-009 SHALL have port ImemRespValid  in  1  response data valid; in order; no backpressure.
REQ-010 SHALL have port ImemRespData  in  WORD_SIZE  fetched instruction word.
REQ-011 SHALL have port Redirect  in  1  branch/jump taken; restart fetch.
REQ-012 SHALL have port RedirectPC  in  WORD_SIZE  restart address; bits [1:0] ignored.
REQ-013 SHALL have port InstrValid  out  1  Instr/InstrPC valid to decode.
REQ-014 SHALL have port InstrReady  in  1  decode consumes; low = decode stall.
REQ-015 SHALL have port Instr  out  WORD_SIZE  instruction word driving decode and immediate extension.
REQ-016 SHALL have port InstrPC  out  WORD_SIZE  address of Instr.

Function
REQ-017 SHALL issue a request (handshake) only when ImemReqValid && ImemReqReady on the same edge; ImemReqAddr = PC.
REQ-018 SHALL advance PC by 4 on each accepted request, wrapping modulo 2^WORD_SIZE.
REQ-019 SHALL drive ImemReqValid = 1 only when !Redirect, state RUN, and (outstanding + buffer count) < DEPTH, guaranteeing every response has a slot.
REQ-020 SHALL push each live response (ImemRespData plus its issue address, held in an address queue of DEPTH entries) into the fetch buffer.
REQ-021 SHALL present the buffer head registered: InstrValid = buffer non-empty; no combinational path from ImemResp* to Instr*.
REQ-022 SHALL pop the head when InstrValid && InstrReady; Instr/InstrPC stay stable while InstrValid && !InstrReady.
REQ-023 SHALL allow push and pop on the same edge, count unchanged, including at full.
REQ-024 SHALL, with ImemReqReady = 1 and one-cycle memory latency, present the instruction at RESET_PC with InstrValid on the second edge after reset release (request edge 0, response cycle 1, valid after edge 1).
REQ-025 SHALL, on Redirect = 1: PC <= {RedirectPC[WORD_SIZE-1:2],2'b00}; buffer and address queue emptied; InstrValid low next cycle; no request that cycle.
REQ-026 SHALL set drop count = outstanding requests not returned at the redirect edge (a response arriving that same cycle counts as returned and is discarded).
REQ-027 SHALL use states RUN and DRAIN: RUN->DRAIN on Redirect with drop count > 0; DRAIN->RUN when last stale response discarded; RUN->RUN on Redirect with drop count = 0.
REQ-028 SHALL discard responses in DRAIN and issue no requests in DRAIN.
REQ-029 SHALL treat Redirect during DRAIN as a new redirect: PC reloaded, drop count unchanged (still-outstanding only).
REQ-030 SHALL give Redirect priority over push, pop and issue on the same edge.

Reset
REQ-031 SHALL, while reset_n = 0 at a rising edge: PC = RESET_PC, state RUN, buffer empty, outstanding = 0, drop count = 0.
REQ-032 SHALL hold outputs during reset: ImemReqValid = 0, InstrValid = 0, Instr = 0, InstrPC = 0, ImemReqAddr = RESET_PC.
REQ-033 SHALL ignore ImemResp* during reset; reset mid-flight abandons outstanding responses (memory reset by same reset_n).

Structure
REQ-034 SHALL place the fetch-state enum (RUN, DRAIN) and WORD_SIZE constant in the shared HighLevelControl package.
REQ-035 SHALL implement buffer and address queue as one parameterised sub-module, fetch_fifo (DEPTH entries, 2*WORD_SIZE wide, flush input).

Verification
REQ-036 Reset release, ready memory, latency 1, InstrReady = 1 -> InstrPC 0x0,0x4,0x8 on consecutive cycles, first valid after edge 1.
REQ-037 InstrReady = 0 for 5 cycles -> exactly DEPTH requests issued, ImemReqValid low thereafter, Instr stable; release -> in-order 0x0,0x4.
REQ-038 Redirect to 0x103 with 2 requests outstanding -> next ImemReqAddr 0x100 only after 2 responses discarded; first InstrPC 0x100.
REQ-039 Redirect same cycle as response and pop -> response discarded, buffer empty, InstrValid low next cycle.
REQ-040 ImemReqReady toggling 1/0, memory latency 3 -> no lost/duplicated PCs; sequence strictly +4.
REQ-041 reset_n low mid-DRAIN for one edge -> all REQ-031 values restored, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/instruction_fetch_unit_pkg.sv
// Shared fetch-control definitions: fetch FSM states and the default datapath width.
package HighLevelControl;

  localparam int WORD_SIZE = 32;

  typedef enum logic {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/instruction_fetch_unit_fifo.sv
// Small circular FIFO with flush, used both as the fetch buffer and as the
// in-flight address queue.
module fetch_fifo #(
  parameter int W     = 64,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic [W-1:0]             push_data,
  input  logic                     pop,
  output logic [W-1:0]             head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign do_pop  = pop && (count != '0);
  // A push into a full FIFO is accepted only when the head leaves on the same edge.
  assign do_push = push && ((count != (AW+1)'(DEPTH)) || do_pop);

  always_ff @(posedge clk) begin
    if (!reset_n || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch: issues sequential word fetches, buffers in-order responses
// for decode, and drains stale responses after a redirect.
module instruction_fetch_unit #(
  parameter int                                  WORD_SIZE = HighLevelControl::WORD_SIZE,
  parameter logic [WORD_SIZE-1:0]                RESET_PC  = WORD_SIZE'(32'h0000_0000),
  parameter int                                  DEPTH     = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  output logic                 ImemReqValid,
  input  logic                 ImemReqReady,
  output logic [WORD_SIZE-1:0] ImemReqAddr,
  input  logic                 ImemRespValid,
  input  logic [WORD_SIZE-1:0] ImemRespData,
  input  logic                 Redirect,
  input  logic [WORD_SIZE-1:0] RedirectPC,
  output logic                 InstrValid,
  input  logic                 InstrReady,
  output logic [WORD_SIZE-1:0] Instr,
  output logic [WORD_SIZE-1:0] InstrPC
);

  import HighLevelControl::*;

  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_e           state;
  logic [WORD_SIZE-1:0]   pc;
  logic [CW-1:0]          outstanding;
  logic [CW-1:0]          drop_cnt;
  logic [CW-1:0]          out_ret;
  logic [CW-1:0]          buf_count;
  logic [CW-1:0]          aq_count_unused;
  logic [CW:0]            occupancy;
  logic [WORD_SIZE-1:0]   aq_head;
  logic [2*WORD_SIZE-1:0] buf_head;
  logic                   issue;
  logic                   resp_ret;
  logic                   resp_live;
  logic                   buf_pop;
  logic                   unused_redirect_lsbs;

  assign unused_redirect_lsbs = ^RedirectPC[1:0];

  // Counting buffered entries alongside in-flight requests guarantees a slot per response.
  assign occupancy    = {1'b0, outstanding} + {1'b0, buf_count};
  assign ImemReqValid = reset_n && !Redirect && (state == RUN) && (occupancy < (CW+1)'(DEPTH));
  assign ImemReqAddr  = pc;
  assign issue        = ImemReqValid && ImemReqReady;

  assign resp_ret  = reset_n && ImemRespValid && (outstanding != '0);
  assign resp_live = resp_ret && (state == RUN) && !Redirect;
  assign out_ret   = outstanding - CW'(resp_ret);

  assign InstrValid = reset_n && (buf_count != '0);
  assign buf_pop    = InstrValid && InstrReady && !Redirect;
  assign Instr      = InstrValid ? buf_head[WORD_SIZE-1:0] : '0;
  assign InstrPC    = InstrValid ? buf_head[2*WORD_SIZE-1:WORD_SIZE] : '0;

  fetch_fifo #(.W(WORD_SIZE), .DEPTH(DEPTH)) addr_q (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (Redirect),
    .push      (issue),
    .push_data (pc),
    .pop       (resp_live),
    .head      (aq_head),
    .count     (aq_count_unused)
  );

  fetch_fifo #(.W(2*WORD_SIZE), .DEPTH(DEPTH)) fetch_buf (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (Redirect),
    .push      (resp_live),
    .push_data ({aq_head, ImemRespData}),
    .pop       (buf_pop),
    .head      (buf_head),
    .count     (buf_count)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= RUN;
      pc          <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else if (Redirect) begin
      // Everything still in flight after this edge is stale and must be dropped.
      pc          <= {RedirectPC[WORD_SIZE-1:2], 2'b00};
      outstanding <= out_ret;
      drop_cnt    <= out_ret;
      state       <= (out_ret != '0) ? DRAIN : RUN;
    end else begin
      if (issue) pc <= pc + WORD_SIZE'(4);
      outstanding <= out_ret + CW'(issue);
      if ((state == DRAIN) && resp_ret) begin
        drop_cnt <= drop_cnt - CW'(1);
        if (drop_cnt == CW'(1)) state <= RUN;
      end
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit with a latency-programmable memory model.
module tb_instruction_fetch_unit;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        ImemReqValid;
  logic        mem_ready = 1'b1;
  logic [31:0] ImemReqAddr;
  logic        mem_vld = 1'b0;
  logic [31:0] mem_data = '0;
  logic        Redirect = 1'b0;
  logic [31:0] RedirectPC = '0;
  logic        InstrValid;
  logic        InstrReady = 1'b1;
  logic [31:0] Instr;
  logic [31:0] InstrPC;

  int n_cmp = 0;
  int n_err = 0;
  int mem_lat = 1;
  int cyc = 0;
  int req_cnt = 0;
  logic [31:0] pend_addr [$];
  int          pend_due  [$];
  logic [31:0] pop_pc    [$];
  logic [31:0] pop_ins   [$];

  instruction_fetch_unit #(.WORD_SIZE(32), .RESET_PC(32'h0000_0000), .DEPTH(DEPTH)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .ImemReqValid  (ImemReqValid),
    .ImemReqReady  (mem_ready),
    .ImemReqAddr   (ImemReqAddr),
    .ImemRespValid (mem_vld),
    .ImemRespData  (mem_data),
    .Redirect      (Redirect),
    .RedirectPC    (RedirectPC),
    .InstrValid    (InstrValid),
    .InstrReady    (InstrReady),
    .Instr         (Instr),
    .InstrPC       (InstrPC)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] fmem(input logic [31:0] a);
    return a ^ 32'hC0DE_5A00;
  endfunction

  // Memory: in-order, fixed latency, reset together with the fetch unit.
  always @(posedge clk) begin
    if (!reset_n) begin
      pend_addr.delete();
      pend_due.delete();
      mem_vld  <= 1'b0;
      mem_data <= '0;
    end else begin
      if (ImemReqValid && mem_ready) begin
        pend_addr.push_back(ImemReqAddr);
        pend_due.push_back(cyc + mem_lat - 1);
        req_cnt++;
      end
      if (pend_addr.size() > 0 && pend_due[0] <= cyc) begin
        mem_vld  <= 1'b1;
        mem_data <= fmem(pend_addr[0]);
        void'(pend_addr.pop_front());
        void'(pend_due.pop_front());
      end else begin
        mem_vld <= 1'b0;
      end
      if (InstrValid && InstrReady && !Redirect) begin
        pop_pc.push_back(InstrPC);
        pop_ins.push_back(Instr);
      end
    end
    cyc++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_reset(input int lat);
    reset_n    = 1'b0;
    Redirect   = 1'b0;
    RedirectPC = '0;
    mem_ready  = 1'b1;
    InstrReady = 1'b1;
    mem_lat    = lat;
    tick();
    tick();
  endtask

  task automatic wait_valid(input string tag, input int maxc);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      if (InstrValid) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    chk(tag, 32'(ok), 32'd1);
  endtask

  initial begin
    int base;
    int n;

    // Reset values and basic streaming at latency 1
    do_reset(1);
    chk("rst_reqvalid", 32'(ImemReqValid), 32'd0);
    chk("rst_instrvalid", 32'(InstrValid), 32'd0);
    chk("rst_instr", Instr, 32'h0);
    chk("rst_instrpc", InstrPC, 32'h0);
    chk("rst_reqaddr", ImemReqAddr, 32'h0);
    reset_n = 1'b1;
    #1;
    chk("rel_reqvalid", 32'(ImemReqValid), 32'd1);
    chk("rel_reqaddr", ImemReqAddr, 32'h0);
    tick();
    chk("e0_instrvalid", 32'(InstrValid), 32'd0);
    chk("e0_reqaddr", ImemReqAddr, 32'h4);
    tick();
    chk("e1_instrvalid", 32'(InstrValid), 32'd1);
    chk("e1_pc", InstrPC, 32'h0);
    chk("e1_instr", Instr, fmem(32'h0));
    tick();
    chk("e2_pc", InstrPC, 32'h4);
    chk("e2_instr", Instr, fmem(32'h4));
    tick();
    chk("e3_valid", 32'(InstrValid), 32'd1);
    chk("e3_pc", InstrPC, 32'h8);

    // Decode stall: only DEPTH requests may be issued
    do_reset(1);
    InstrReady = 1'b0;
    base = req_cnt;
    reset_n = 1'b1;
    tick();
    tick();
    chk("stall_e1_pc", InstrPC, 32'h0);
    tick();
    tick();
    tick();
    chk("stall_reqs", 32'(req_cnt - base), 32'(DEPTH));
    chk("stall_reqvalid", 32'(ImemReqValid), 32'd0);
    chk("stall_valid", 32'(InstrValid), 32'd1);
    chk("stall_pc", InstrPC, 32'h0);
    chk("stall_instr", Instr, fmem(32'h0));
    InstrReady = 1'b1;
    tick();
    chk("unstall_pc", InstrPC, 32'h4);
    chk("unstall_reqvalid", 32'(ImemReqValid), 32'd1);
    chk("unstall_reqaddr", ImemReqAddr, 32'h10);

    // Redirect with two requests outstanding, latency 3
    do_reset(3);
    reset_n = 1'b1;
    tick();
    tick();
    Redirect   = 1'b1;
    RedirectPC = 32'h103;
    #1;
    chk("redir_noreq", 32'(ImemReqValid), 32'd0);
    tick();
    Redirect = 1'b0;
    #1;
    chk("drain1_reqvalid", 32'(ImemReqValid), 32'd0);
    chk("drain1_valid", 32'(InstrValid), 32'd0);
    tick();
    chk("drain2_reqvalid", 32'(ImemReqValid), 32'd0);
    chk("drain2_valid", 32'(InstrValid), 32'd0);
    tick();
    chk("drained_reqvalid", 32'(ImemReqValid), 32'd1);
    chk("drained_reqaddr", ImemReqAddr, 32'h100);
    wait_valid("redir_wait", 10);
    chk("redir_pc", InstrPC, 32'h100);
    chk("redir_instr", Instr, fmem(32'h100));

    // Redirect on the same edge as a response and a pop
    do_reset(1);
    reset_n = 1'b1;
    tick();
    tick();
    tick();
    Redirect   = 1'b1;
    RedirectPC = 32'h200;
    tick();
    Redirect = 1'b0;
    #1;
    chk("same_valid", 32'(InstrValid), 32'd0);
    chk("same_reqvalid", 32'(ImemReqValid), 32'd1);
    chk("same_reqaddr", ImemReqAddr, 32'h200);
    tick();
    chk("same_stale_gone", 32'(InstrValid), 32'd0);
    tick();
    chk("same_new_valid", 32'(InstrValid), 32'd1);
    chk("same_new_pc", InstrPC, 32'h200);

    // Toggling memory ready with latency 3: strictly sequential PCs
    do_reset(3);
    base = pop_pc.size();
    reset_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick();
      mem_ready = ~mem_ready;
    end
    mem_ready = 1'b1;
    n = pop_pc.size() - base;
    chk("seq_enough", 32'(n >= 10), 32'd1);
    for (int i = 0; i < n; i++) begin
      chk("seq_pc", pop_pc[base+i], 32'(4 * i));
      chk("seq_instr", pop_ins[base+i], fmem(32'(4 * i)));
    end

    // Reset asserted for one edge while draining
    do_reset(3);
    reset_n = 1'b1;
    tick();
    tick();
    Redirect   = 1'b1;
    RedirectPC = 32'h300;
    tick();
    Redirect = 1'b0;
    #1;
    chk("mid_drain_reqvalid", 32'(ImemReqValid), 32'd0);
    reset_n = 1'b0;
    tick();
    chk("rst2_reqvalid", 32'(ImemReqValid), 32'd0);
    chk("rst2_instrvalid", 32'(InstrValid), 32'd0);
    chk("rst2_instr", Instr, 32'h0);
    chk("rst2_instrpc", InstrPC, 32'h0);
    chk("rst2_reqaddr", ImemReqAddr, 32'h0);
    reset_n = 1'b1;
    #1;
    chk("rst2_rel_reqvalid", 32'(ImemReqValid), 32'd1);
    chk("rst2_rel_reqaddr", ImemReqAddr, 32'h0);
    wait_valid("rst2_wait", 10);
    chk("rst2_first_pc", InstrPC, 32'h0);
    chk("rst2_first_instr", Instr, fmem(32'h0));
    tick();
    chk("rst2_second_pc", InstrPC, 32'h4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
